rm_prog_automaton: RTL and testbench

//  Runtime-programmable homogeneous automaton engine for the runtime-monitor (RM) clusters.

---
 rtl/rm_automata_pkg.sv | 18 +
 rtl/rm_prog_automaton_if.sv | 42 ++++
 rtl/rm_report_fifo.sv | 69 ++++++
 rtl/rm_prog_automaton.sv | 120 ++++++++++++
 tb/tb_rm_prog_automaton.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/rm_automata_pkg.sv
// Shared types for the runtime-programmable automaton engine.
// Start-type encoding and the interval-match helper used per STE.
package rm_automata_pkg;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SOD  = 2'd1,
        ST_ALL  = 2'd2
    } start_type_e;

    // Operands arrive zero-extended so one helper serves any symbol width.
    function automatic logic sym_in_range(input logic [63:0] sym,
                                          input logic [63:0] lo,
                                          input logic [63:0] hi);
        return (sym >= lo) && (sym <= hi);
    endfunction

endpackage

// File: rtl/rm_prog_automaton_if.sv
// Bundle of the symbol stream, configuration port and report drain.
// master = driver of symbols/config and consumer of reports; slave = engine.
interface rm_prog_automaton_if #(
    parameter int N_STE = 16,
    parameter int SYM_W = 8,
    parameter int IDX_W = 16
);
    localparam int STE_W = (N_STE > 1) ? $clog2(N_STE) : 1;

    logic                  run;
    logic                  flush;
    logic [SYM_W-1:0]      symbols;
    logic                  cfg_we;
    logic [STE_W-1:0]      cfg_ste;
    logic [SYM_W-1:0]      cfg_lo;
    logic [SYM_W-1:0]      cfg_hi;
    logic [N_STE-1:0]      cfg_edges;
    logic [1:0]            cfg_start;
    logic                  cfg_report;
    logic                  cfg_err;
    logic [N_STE-1:0]      active;
    logic                  rpt_valid;
    logic                  rpt_ready;
    logic [IDX_W-1:0]      rpt_idx;
    logic [N_STE-1:0]      rpt_vec;
    logic                  rpt_ovf;

    modport master (
        output run, flush, symbols,
        output cfg_we, cfg_ste, cfg_lo, cfg_hi, cfg_edges, cfg_start, cfg_report,
        output rpt_ready,
        input  cfg_err, active, rpt_valid, rpt_idx, rpt_vec, rpt_ovf
    );

    modport slave (
        input  run, flush, symbols,
        input  cfg_we, cfg_ste, cfg_lo, cfg_hi, cfg_edges, cfg_start, cfg_report,
        input  rpt_ready,
        output cfg_err, active, rpt_valid, rpt_idx, rpt_vec, rpt_ovf
    );

endinterface

// File: rtl/rm_report_fifo.sv
// Synchronous report FIFO with valid/ready pop and a sticky drop flag.
// A push into a full FIFO succeeds only when the same cycle pops.
module rm_report_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data,
    output logic             o_drop
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_drop;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_wr;

    assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty;
    assign w_wr    = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && !w_wr) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Storage is not reset; the head is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_empty = w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_drop  = r_drop;

endmodule

// File: rtl/rm_prog_automaton.sv
// Runtime-programmable homogeneous automaton: N_STE state-transition elements
// with interval match, edge masks and start types; report hits go to a FIFO.
module rm_prog_automaton #(
    parameter int N_STE      = 16,
    parameter int SYM_W      = 8,
    parameter int IDX_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    rm_prog_automaton_if.slave bus
);
    import rm_automata_pkg::*;

    localparam int              STE_W   = (N_STE > 1) ? $clog2(N_STE) : 1;
    localparam logic [STE_W:0]  N_STE_V = (STE_W+1)'(N_STE);
    localparam int              RPT_W   = IDX_W + N_STE;

    typedef struct packed {
        logic [SYM_W-1:0] lo;
        logic [SYM_W-1:0] hi;
        logic [N_STE-1:0] edges;
        start_type_e      start;
        logic             report;
    } ste_cfg_t;

    ste_cfg_t         r_cfg [N_STE];
    logic [N_STE-1:0] r_active;
    logic [IDX_W-1:0] r_idx;
    logic             r_sod_armed;
    logic             r_cfg_err;

    logic [N_STE-1:0] w_match;
    logic [N_STE-1:0] w_en;
    logic [N_STE-1:0] w_next;
    logic [N_STE-1:0] w_report_mask;
    logic [N_STE-1:0] w_rpt_vec;
    logic             w_cfg_bad;
    logic             w_push;
    logic             w_fifo_empty;
    logic             w_fifo_drop;
    logic [RPT_W-1:0] w_fifo_data;

    // Reconfiguring while symbols flow would corrupt the running graph.
    assign w_cfg_bad = bus.run || ({1'b0, bus.cfg_ste} >= N_STE_V);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_err <= 1'b0;
            for (int i = 0; i < N_STE; i++) begin
                r_cfg[i] <= '{lo: '1, hi: '0, edges: '0, start: ST_NONE, report: 1'b0};
            end
        end else begin
            r_cfg_err <= bus.cfg_we && w_cfg_bad;
            if (bus.cfg_we && !w_cfg_bad) begin
                r_cfg[bus.cfg_ste] <= '{lo:     bus.cfg_lo,
                                        hi:     bus.cfg_hi,
                                        edges:  bus.cfg_edges,
                                        start:  start_type_e'(bus.cfg_start),
                                        report: bus.cfg_report};
            end
        end
    end

    always_comb begin
        w_match       = '0;
        w_en          = '0;
        w_report_mask = '0;
        for (int i = 0; i < N_STE; i++) begin
            w_match[i]       = sym_in_range(64'(bus.symbols), 64'(r_cfg[i].lo), 64'(r_cfg[i].hi));
            w_en[i]          = (|(r_cfg[i].edges & r_active))
                             || ((r_cfg[i].start == ST_SOD) && r_sod_armed)
                             || (r_cfg[i].start == ST_ALL);
            w_report_mask[i] = r_cfg[i].report;
        end
        w_next    = w_match & w_en;
        w_rpt_vec = w_next & w_report_mask;
    end

    // flush wins over run: the symbol presented with flush is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active    <= '0;
            r_idx       <= '0;
            r_sod_armed <= 1'b1;
        end else if (bus.flush) begin
            r_active    <= '0;
            r_idx       <= '0;
            r_sod_armed <= 1'b1;
        end else if (bus.run) begin
            r_active    <= w_next;
            r_idx       <= r_idx + IDX_W'(1);
            r_sod_armed <= 1'b0;
        end
    end

    assign w_push = bus.run && !bus.flush && (|w_rpt_vec);

    rm_report_fifo #(
        .WIDTH (RPT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({r_idx, w_rpt_vec}),
        .i_pop   (bus.rpt_ready),
        .o_empty (w_fifo_empty),
        .o_data  (w_fifo_data),
        .o_drop  (w_fifo_drop)
    );

    assign bus.cfg_err   = r_cfg_err;
    assign bus.active    = r_active;
    assign bus.rpt_valid = !w_fifo_empty;
    assign bus.rpt_idx   = w_fifo_data[RPT_W-1:N_STE];
    assign bus.rpt_vec   = w_fifo_data[N_STE-1:0];
    assign bus.rpt_ovf   = w_fifo_drop;

endmodule

// File: tb/tb_rm_prog_automaton.sv
// Directed bench for rm_prog_automaton: inputs driven and outputs checked
// on the falling edge, all state changes happen on the rising edge.
module tb_rm_prog_automaton;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic any_act;
    logic any_vld;
    logic [15:0] exp_idx;

    rm_prog_automaton_if #(.N_STE(16), .SYM_W(8), .IDX_W(16)) bus();

    rm_prog_automaton #(
        .N_STE      (16),
        .SYM_W      (8),
        .IDX_W      (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] ste, input logic [7:0] lo, input logic [7:0] hi,
                             input logic [15:0] edges, input logic [1:0] st, input logic rep);
        @(negedge clk);
        bus.cfg_we     = 1'b1;
        bus.cfg_ste    = ste;
        bus.cfg_lo     = lo;
        bus.cfg_hi     = hi;
        bus.cfg_edges  = edges;
        bus.cfg_start  = st;
        bus.cfg_report = rep;
        @(negedge clk);
        bus.cfg_we     = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.run        = 1'b0;
        bus.flush      = 1'b0;
        bus.symbols    = '0;
        bus.cfg_we     = 1'b0;
        bus.cfg_ste    = '0;
        bus.cfg_lo     = '0;
        bus.cfg_hi     = '0;
        bus.cfg_edges  = '0;
        bus.cfg_start  = '0;
        bus.cfg_report = 1'b0;
        bus.rpt_ready  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_active",  64'(bus.active),    64'h0);
        check("rst_valid",   64'(bus.rpt_valid), 64'h0);
        check("rst_ovf",     64'(bus.rpt_ovf),   64'h0);
        check("rst_cfg_err", 64'(bus.cfg_err),   64'h0);
        check("rst_idx",     64'(bus.rpt_idx),   64'h0);

        // Unconfigured engine: nothing may ever match.
        any_act = 1'b0;
        any_vld = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            any_act = any_act | (|bus.active);
            any_vld = any_vld | bus.rpt_valid;
            bus.run     = 1'b1;
            bus.symbols = 8'(i);
        end
        @(negedge clk);
        bus.run = 1'b0;
        any_act = any_act | (|bus.active);
        any_vld = any_vld | bus.rpt_valid;
        check("noconf_active", 64'(any_act), 64'h0);
        check("noconf_valid",  64'(any_vld), 64'h0);

        // Two-node graph: STE0 [0,63] SOD self-loop, STE1 [64,127] fed by STE0, reports.
        do_flush();
        cfg_write(4'd0, 8'd0, 8'd63, 16'h0001, 2'd1, 1'b0);
        check("cfg_ok_err", 64'(bus.cfg_err), 64'h0);
        cfg_write(4'd1, 8'd64, 8'd127, 16'h0001, 2'd0, 1'b1);
        @(negedge clk);
        bus.run     = 1'b1;
        bus.symbols = 8'd10;
        @(negedge clk);
        check("g_act10",   64'(bus.active),    64'h1);
        check("g_vld10",   64'(bus.rpt_valid), 64'h0);
        bus.symbols = 8'd70;
        @(negedge clk);
        check("g_act70",   64'(bus.active),    64'h2);
        check("g_vld70",   64'(bus.rpt_valid), 64'h1);
        check("g_idx70",   64'(bus.rpt_idx),   64'h1);
        check("g_vec70",   64'(bus.rpt_vec),   64'h2);
        bus.run       = 1'b0;
        bus.rpt_ready = 1'b1;
        @(negedge clk);
        check("g_popped",  64'(bus.rpt_valid), 64'h0);
        check("g_hold",    64'(bus.active),    64'h2);
        bus.rpt_ready = 1'b0;

        // STE1 is not a start node; a rejected write while running must not land.
        do_flush();
        @(negedge clk);
        bus.run     = 1'b1;
        bus.symbols = 8'd70;
        @(negedge clk);
        check("s_act70",   64'(bus.active), 64'h0);
        bus.symbols    = 8'd10;
        bus.cfg_we     = 1'b1;
        bus.cfg_ste    = 4'd3;
        bus.cfg_lo     = 8'd0;
        bus.cfg_hi     = 8'd255;
        bus.cfg_edges  = 16'h0;
        bus.cfg_start  = 2'd2;
        bus.cfg_report = 1'b1;
        @(negedge clk);
        check("s_cfg_err", 64'(bus.cfg_err), 64'h1);
        check("s_sod_gone", 64'(bus.active), 64'h0);
        bus.cfg_we  = 1'b0;
        bus.symbols = 8'd5;
        @(negedge clk);
        check("s_err_pulse", 64'(bus.cfg_err),   64'h0);
        check("s_rejected",  64'(bus.active),    64'h0);
        check("s_no_rpt",    64'(bus.rpt_valid), 64'h0);
        bus.run = 1'b0;

        // STE2 matches everything and reports: overfill the FIFO.
        cfg_write(4'd2, 8'd0, 8'd255, 16'h0, 2'd2, 1'b1);
        do_flush();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 8) check("f_ovf_at8", 64'(bus.rpt_ovf), 64'h0);
            if (i == 9) check("f_ovf_at9", 64'(bus.rpt_ovf), 64'h1);
            bus.run     = 1'b1;
            bus.symbols = 8'(200 + i);
        end
        @(negedge clk);
        bus.run = 1'b0;
        check("f_valid",  64'(bus.rpt_valid), 64'h1);
        check("f_ovf",    64'(bus.rpt_ovf),   64'h1);
        check("f_idx0",   64'(bus.rpt_idx),   64'h0);
        check("f_vec",    64'(bus.rpt_vec),   64'h4);
        check("f_active", 64'(bus.active),    64'h4);
        @(negedge clk);
        check("f_stable", 64'(bus.rpt_idx),   64'h0);

        // Push and pop together on a full FIFO: both succeed, index 10 enters.
        bus.run       = 1'b1;
        bus.symbols   = 8'd210;
        bus.rpt_ready = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        check("pp_ovf", 64'(bus.rpt_ovf), 64'h1);
        for (int k = 0; k < 8; k++) begin
            exp_idx = (k < 7) ? 16'(k + 1) : 16'd10;
            check("drain_valid", 64'(bus.rpt_valid), 64'h1);
            check("drain_idx",   64'(bus.rpt_idx),   64'(exp_idx));
            @(negedge clk);
        end
        check("drain_empty", 64'(bus.rpt_valid), 64'h0);
        check("drain_ovf",   64'(bus.rpt_ovf),   64'h1);
        @(negedge clk);
        check("pop_empty_valid", 64'(bus.rpt_valid), 64'h0);
        check("pop_empty_vec",   64'(bus.rpt_vec),   64'h0);
        bus.rpt_ready = 1'b0;

        // flush beats run in the same cycle; index restarts at zero.
        @(negedge clk);
        bus.flush   = 1'b1;
        bus.run     = 1'b1;
        bus.symbols = 8'd200;
        @(negedge clk);
        bus.flush = 1'b0;
        check("fl_active", 64'(bus.active),    64'h0);
        check("fl_valid",  64'(bus.rpt_valid), 64'h0);
        bus.symbols = 8'd220;
        @(negedge clk);
        check("fl_rvalid", 64'(bus.rpt_valid), 64'h1);
        check("fl_idx",    64'(bus.rpt_idx),   64'h0);
        check("fl_vec",    64'(bus.rpt_vec),   64'h4);
        check("fl_act",    64'(bus.active),    64'h4);
        check("fl_ovf",    64'(bus.rpt_ovf),   64'h1);

        // Reset while running clears state, FIFO, overflow and configuration.
        reset       = 1'b1;
        bus.symbols = 8'd230;
        @(negedge clk);
        reset = 1'b0;
        check("mr_active",  64'(bus.active),    64'h0);
        check("mr_valid",   64'(bus.rpt_valid), 64'h0);
        check("mr_idx",     64'(bus.rpt_idx),   64'h0);
        check("mr_vec",     64'(bus.rpt_vec),   64'h0);
        check("mr_ovf",     64'(bus.rpt_ovf),   64'h0);
        check("mr_cfg_err", 64'(bus.cfg_err),   64'h0);
        bus.symbols = 8'd0;
        @(negedge clk);
        check("mr_cfg0_act", 64'(bus.active),    64'h0);
        check("mr_cfg0_vld", 64'(bus.rpt_valid), 64'h0);
        bus.symbols = 8'd240;
        @(negedge clk);
        check("mr_cfg2_act", 64'(bus.active),    64'h0);
        check("mr_cfg2_vld", 64'(bus.rpt_valid), 64'h0);
        bus.run = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
